vga_sync_bounce: RTL
====================

// Module: vga_sync_bounce
// PURPOSE
//  Drives the scan side of the 640x480@60 VGA sprite path: pixel-rate hc/vc counters,
//  hsync/vsync, vidon, and the bouncing sprite origin C1/R1 used by the sprite renderer.
//  Sits between the board clock and the sprite renderer/ROM. C1/R1 move once per frame
//  and reflect off the active-area edges.
// PARAMETERS
//  CLK_DIV  4    clk cycles per pixel (100 MHz -> 25 MHz pixel tick); >=1
//  HPIXELS  800  pixels per line; VLINES 521 lines per frame
//  HPULSE   128  hsync low width; VPULSE 2 vsync low width (lines)
//  HBP      144  first active column; HFP 784 first column after active area
//  VBP      31   first active line;   VFP 511 first line after active area
//  W        240  sprite width;  H 160 sprite height
//  DX       2    C1 step per frame; DY 1 R1 step per frame
// PORTS
//  clk     in   1   system clock
//  rst_n   in   1   async active-low reset
//  run     in   1   1 = sprite moves at frame boundary, 0 = C1/R1 hold
//  hc      out  11  horizontal counter, 0..HPIXELS-1
//  vc      out  11  vertical counter, 0..VLINES-1
//  hsync   out  1   low while hc < HPULSE
//  vsync   out  1   low while vc < VPULSE
//  vidon   out  1   1 when HBP<=hc<HFP and VBP<=vc<VFP
//  C1      out  10  sprite column origin, 0..(HFP-HBP-W)=400
//  R1      out  10  sprite row origin, 0..(VFP-VBP-H)=320
//  frame   out  1   one-clk pulse on the pixel tick where hc,vc wrap to 0,0
// BEHAVIOUR
//  - Reset (async, rst_n=0): div=0, hc=0, vc=0, C1=0, R1=0, xdir=+, ydir=+, frame=0.
//    hsync=0, vsync=0, vidon=0 then follow by decode of hc/vc. Release synchronous to clk.
//  - Divider: div counts 0..CLK_DIV-1; tick = (div==CLK_DIV-1). hc/vc/C1/R1 change only on tick.
//  - On tick: hc==HPIXELS-1 -> hc=0 and vc advances (vc==VLINES-1 -> vc=0); else hc+1.
//  - hsync/vsync/vidon: combinational decode of registered hc/vc, zero latency vs counters.
//  - frame: registered; 1 for exactly one clk, the cycle after the tick that loads hc=0,vc=0.
//  - Motion, same tick as the frame wrap, only if run=1:
//    x: xdir=+ : if C1+DX >= XMAX (400) -> C1=XMAX, xdir=-; else C1+=DX.
//       xdir=- : if C1 <= DX -> C1=0, xdir=+; else C1-=DX.
//    y: same rule with R1, DY, YMAX (320), ydir. Compare in 11 bits; no wrap/underflow ever.
//  - Simultaneous corner hit: both axes clamp and reverse in the same update.
//  - run toggled mid-frame: sampled only at the wrap tick; C1/R1 never change mid-frame,
//    so the sprite never tears.
//  - rst_n low mid-frame: immediate return to reset state; first post-reset frame
//    starts at hc=0,vc=0.
//  - C1/R1 always satisfy C1+W <= 640 and R1+H <= 480 (sprite fully on screen).
// TESTING
//  1 Reset then 4*800*521 clks -> exactly one frame pulse; hsync low 128 px/line; vsync low 2 lines.
//  2 Scan one line -> vidon rises at hc=144, falls at hc=784 (vc in 31..510); 0 at vc=30 and 511.
//  3 run=1 from reset -> after 1 frame C1=2,R1=1; after 200 frames C1=400, xdir=-; frame 201 C1=398.
//  4 run=0 for 10 frames after C1=50 -> C1/R1 unchanged; toggle run mid-frame -> no change until wrap.
//  5 DX=DY=1, preset path to corner -> C1=400 and R1=320 on same update, both dirs reverse.
//  6 Assert rst_n at hc=300,vc=200 -> all outputs at reset values same cycle, clean restart.

Source files
------------

// File: rtl/vga_sync_bounce.sv
// VGA scan timing (hc/vc, hsync/vsync, vidon) plus a bouncing sprite origin (C1/R1)
// that steps once per frame and reflects off the edges of the active area.
module vga_sync_bounce #(
    parameter int CLK_DIV = 4,
    parameter int HPIXELS = 800,
    parameter int VLINES  = 521,
    parameter int HPULSE  = 128,
    parameter int VPULSE  = 2,
    parameter int HBP     = 144,
    parameter int HFP     = 784,
    parameter int VBP     = 31,
    parameter int VFP     = 511,
    parameter int W       = 240,
    parameter int H       = 160,
    parameter int DX      = 2,
    parameter int DY      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic [10:0] hc,
    output logic [10:0] vc,
    output logic        hsync,
    output logic        vsync,
    output logic        vidon,
    output logic [9:0]  C1,
    output logic [9:0]  R1,
    output logic        frame
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [10:0] H_LAST  = 11'(HPIXELS - 1);
    localparam logic [10:0] V_LAST  = 11'(VLINES - 1);
    localparam logic [10:0] H_PULSE = 11'(HPULSE);
    localparam logic [10:0] V_PULSE = 11'(VPULSE);
    localparam logic [10:0] H_BP    = 11'(HBP);
    localparam logic [10:0] H_FP    = 11'(HFP);
    localparam logic [10:0] V_BP    = 11'(VBP);
    localparam logic [10:0] V_FP    = 11'(VFP);
    localparam logic [10:0] X_LIM   = 11'(HFP - HBP - W);
    localparam logic [10:0] Y_LIM   = 11'(VFP - VBP - H);
    localparam logic [10:0] X_STEP  = 11'(DX);
    localparam logic [10:0] Y_STEP  = 11'(DY);

    typedef enum logic {DIR_POS, DIR_NEG} dir_t;

    typedef struct packed {
        dir_t       dir;
        logic [9:0] pos;
    } axis_t;

    logic [DIV_W-1:0] div;
    logic             tick;
    logic             wrap;
    axis_t            x_q, y_q;
    axis_t            x_next, y_next;

    // One frame's move on one axis; clamps to the edge and reverses instead of overshooting.
    function automatic axis_t bounce(input axis_t cur, input logic [10:0] step,
                                     input logic [10:0] lim);
        axis_t       nxt;
        logic [10:0] pos11;
        nxt   = cur;
        pos11 = {1'b0, cur.pos};
        if (cur.dir == DIR_POS) begin
            if (pos11 + step >= lim) begin
                nxt.pos = lim[9:0];
                nxt.dir = DIR_NEG;
            end else begin
                nxt.pos = 10'(pos11 + step);
            end
        end else begin
            if (pos11 <= step) begin
                nxt.pos = '0;
                nxt.dir = DIR_POS;
            end else begin
                nxt.pos = 10'(pos11 - step);
            end
        end
        return nxt;
    endfunction

    assign tick = (div == DIV_LAST);
    assign wrap = tick && (hc == H_LAST) && (vc == V_LAST);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        x_next = x_q;
        y_next = y_q;
        if (wrap && run) begin
            x_next = bounce(x_q, X_STEP, X_LIM);
            y_next = bounce(y_q, Y_STEP, Y_LIM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div   <= '0;
            hc    <= '0;
            vc    <= '0;
            x_q   <= '{dir: DIR_POS, pos: '0};
            y_q   <= '{dir: DIR_POS, pos: '0};
            frame <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            frame <= wrap;
            x_q   <= x_next;
            y_q   <= y_next;
            if (tick) begin
                div <= '0;
                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? 11'd0 : vc + 11'd1;
                end else begin
                    hc <= hc + 11'd1;
                end
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    assign hsync = (hc >= H_PULSE);
    assign vsync = (vc >= V_PULSE);
    assign vidon = (hc >= H_BP) && (hc < H_FP) && (vc >= V_BP) && (vc < V_FP);
    assign C1    = x_q.pos;
    assign R1    = y_q.pos;

endmodule
